// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, master instruction codes, ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StWaitStop
    } i2c_state_e;

    // Instruction codes understood by the companion I2C master.
    typedef enum logic [1:0] {
        CmdStart = 2'd0,
        CmdStop  = 2'd1,
        CmdRead  = 2'd2,
        CmdWrite = 2'd3
    } i2c_cmd_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for a raw bus line plus single-cycle rise/fall pulses.
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_raw,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize and keep one delayed copy for edge detection; idle bus level is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: write sets pointer then data, read streams data.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    i2c_state_e r_state, w_state_d;
    logic [2:0] r_bit_cnt, w_bit_cnt_d;
    logic [7:0] r_shift, w_shift_d;
    logic [7:0] r_addr, w_addr_d;
    logic [7:0] r_wdata, w_wdata_d;
    logic       r_rw, w_rw_d;
    logic       r_we, w_we_d;
    logic       r_oe, w_oe_d;
    logic       r_busy, w_busy_d;

    i2c_sync_edge u_sync_scl (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_raw  (scl_i),
        .o_sync (w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_sync_edge u_sync_sda (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_raw  (sda_i),
        .o_sync (w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    // Byte as it will look once the current SCL-rise bit is shifted in.
    assign w_byte  = {r_shift[6:0], w_sda};

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw      <= 1'b0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_addr    <= w_addr_d;
            r_wdata   <= w_wdata_d;
            r_rw      <= w_rw_d;
            r_we      <= w_we_d;
            r_oe      <= w_oe_d;
            r_busy    <= w_busy_d;
        end
    end

    // Next-state logic: bits sampled on SCL rise, SDA drive changed only on SCL fall.
    // In ACK states r_oe tells whether the ACK has been driven yet.
    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_rw_d      = r_rw;
        w_we_d      = 1'b0;
        w_oe_d      = r_oe;
        w_busy_d    = r_busy;
        if (w_stop) begin
            w_state_d   = StIdle;
            w_bit_cnt_d = '0;
            w_oe_d      = 1'b0;
            w_busy_d    = 1'b0;
        end else if (w_start) begin
            w_state_d   = StAddr;
            w_bit_cnt_d = '0;
            w_oe_d      = 1'b0;
            w_busy_d    = 1'b0;
        end else begin
            unique case (r_state)
                StAddr: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                w_state_d = StAddrAck;
                                w_rw_d    = w_byte[0];
                                w_busy_d  = 1'b1;
                            end else begin
                                w_state_d = StWaitStop;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_d = '0;
                        if (!r_oe) begin
                            w_oe_d = 1'b1;
                        end else if (r_rw) begin
                            w_state_d = StRdata;
                            w_shift_d = reg_rdata_i;
                            w_oe_d    = ~reg_rdata_i[7];
                        end else begin
                            w_state_d = StPtr;
                            w_oe_d    = 1'b0;
                        end
                    end
                end
                StPtr: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_addr_d  = w_byte;
                            w_state_d = StPtrAck;
                        end
                    end
                end
                StPtrAck: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_d = '0;
                        w_oe_d      = ~r_oe;
                        if (r_oe) begin
                            w_state_d = StWdata;
                        end
                    end
                end
                StWdata: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_wdata_d = w_byte;
                            w_we_d    = 1'b1;
                            w_state_d = StWdataAck;
                        end
                    end
                end
                StWdataAck: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_d = '0;
                        w_oe_d      = ~r_oe;
                        if (r_oe) begin
                            w_addr_d  = r_addr + 8'd1;
                            w_state_d = StWdata;
                        end
                    end
                end
                StRdata: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_d = StRdataAck;
                        end
                    end else if (w_scl_fall) begin
                        w_shift_d = {r_shift[6:0], 1'b0};
                        w_oe_d    = ~r_shift[6];
                    end
                end
                StRdataAck: begin
                    // r_bit_cnt == 1 marks that the master's ACK has been sampled.
                    if (w_scl_fall) begin
                        w_oe_d = 1'b0;
                        if (r_bit_cnt == 3'd1) begin
                            w_state_d   = StRdata;
                            w_bit_cnt_d = '0;
                            w_shift_d   = reg_rdata_i;
                            w_oe_d      = ~reg_rdata_i[7];
                        end
                    end else if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            w_addr_d    = r_addr + 8'd1;
                            w_bit_cnt_d = 3'd1;
                        end else begin
                            w_state_d = StWaitStop;
                        end
                    end
                end
                StIdle, StWaitStop: begin
                    w_oe_d = 1'b0;
                end
                default: begin
                    w_state_d = StIdle;
                    w_oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o    = r_oe;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bus master model drives directed transactions.
module tb_i2c_target;

    localparam int Q = 8;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } obs_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       m_scl;
    logic       m_sda;
    logic       w_sda_bus;
    logic       sda_oe_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    logic [15:0] exp_we_q [$];
    logic [7:0]  exp_bus_q [$];
    obs_t        obs_q [$];

    always #5 clk_i = ~clk_i;

    assign w_sda_bus   = m_sda & ~sda_oe_o;
    assign reg_rdata_i = mem[reg_addr_o];

    i2c_target #(
        .DEV_ADDR (7'h3C)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .scl_i       (m_scl),
        .sda_i       (w_sda_bus),
        .sda_oe_o    (sda_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected write strobes and bus responses as the DUT presents them.
    logic [15:0] mon_we;
    obs_t        mon_obs;
    always @(negedge clk_i) begin
        if (reg_we_o) begin
            if (exp_we_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                mon_we = exp_we_q.pop_front();
                check("we_addr", {24'd0, reg_addr_o}, {24'd0, mon_we[15:8]});
                check("we_data", {24'd0, reg_wdata_o}, {24'd0, mon_we[7:0]});
            end
        end
        if (obs_q.size() != 0) begin
            mon_obs = obs_q.pop_front();
            if (exp_bus_q.size() == 0) begin
                check({mon_obs.tag, "_unexpected"}, 32'd1, 32'd0);
            end else begin
                check(mon_obs.tag, {24'd0, mon_obs.val}, {24'd0, exp_bus_q.pop_front()});
            end
        end
        if (sda_oe_o) oe_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk_i);
        #1;
    endtask

    task automatic m_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic m_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        s = w_sda_bus; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input string tag);
        logic s;
        obs_t o;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        o.tag = tag;
        o.val = {7'd0, s};
        obs_q.push_back(o);
    endtask

    task automatic read_byte(input logic ack, input string tag);
        logic s;
        logic [7:0] d;
        obs_t o;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, s);
            d = {d[6:0], s};
        end
        o.tag = tag;
        o.val = d;
        obs_q.push_back(o);
        m_bit(ack, s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int oe0;
        int busy0;
        logic s;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        rst_ni = 1'b0;
        m_scl  = 1'b1;
        m_sda  = 1'b1;
        wait_q();
        check("rst_oe", {31'd0, sda_oe_o}, 32'd0);
        check("rst_we", {31'd0, reg_we_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_addr", {24'd0, reg_addr_o}, 32'h00);
        check("rst_wdata", {24'd0, reg_wdata_o}, 32'h00);
        rst_ni = 1'b1;
        wait_q();

        // Write: pointer 0x10, data A5, 5A.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "wr_addr_ack");
        check("wr_busy", {31'd0, busy_o}, 32'd1);
        exp_bus_q.push_back(8'h00); write_byte(8'h10, "wr_ptr_ack");
        exp_we_q.push_back(16'h10A5);
        exp_bus_q.push_back(8'h00); write_byte(8'hA5, "wr_d0_ack");
        exp_we_q.push_back(16'h115A);
        exp_bus_q.push_back(8'h00); write_byte(8'h5A, "wr_d1_ack");
        m_stop();
        wait_q();
        check("wr_busy_after_stop", {31'd0, busy_o}, 32'd0);
        check("wr_addr_after", {24'd0, reg_addr_o}, 32'h12);

        // Read: pointer 0x20, repeated START, two bytes ACK then NACK.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "rd_addr_w_ack");
        exp_bus_q.push_back(8'h00); write_byte(8'h20, "rd_ptr_ack");
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h79, "rd_addr_r_ack");
        exp_bus_q.push_back(8'h11); read_byte(1'b0, "rd_byte0");
        exp_bus_q.push_back(8'h22); read_byte(1'b1, "rd_byte1");
        check("rd_oe_after_nack", {31'd0, sda_oe_o}, 32'd0);
        check("rd_addr_after", {24'd0, reg_addr_o}, 32'h21);
        m_stop();
        wait_q();

        // Wrong address: never driven, never busy.
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        m_start();
        exp_bus_q.push_back(8'h01); write_byte(8'h50, "bad_addr_nack");
        exp_bus_q.push_back(8'h01); write_byte(8'h33, "bad_data_nack");
        m_stop();
        wait_q();
        check("bad_oe_cycles", oe_cnt - oe0, 32'd0);
        check("bad_busy_cycles", busy_cnt - busy0, 32'd0);

        // Pointer wrap 0xFF -> 0x00.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "wrap_addr_ack");
        exp_bus_q.push_back(8'h00); write_byte(8'hFF, "wrap_ptr_ack");
        exp_we_q.push_back(16'hFF01);
        exp_bus_q.push_back(8'h00); write_byte(8'h01, "wrap_d0_ack");
        exp_we_q.push_back(16'h0002);
        exp_bus_q.push_back(8'h00); write_byte(8'h02, "wrap_d1_ack");
        m_stop();
        wait_q();
        check("wrap_addr_after", {24'd0, reg_addr_o}, 32'h01);

        // Mid-byte abort: STOP after 4 data bits, no strobe.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "abort_addr_ack");
        exp_bus_q.push_back(8'h00); write_byte(8'h40, "abort_ptr_ack");
        m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
        m_stop();
        wait_q();
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_oe", {31'd0, sda_oe_o}, 32'd0);
        check("abort_addr", {24'd0, reg_addr_o}, 32'h40);

        // Reset during RDATA: register 0x30 reads 0x00 so SDA is being pulled low.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "rst_addr_w_ack");
        exp_bus_q.push_back(8'h00); write_byte(8'h30, "rst_ptr_ack");
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h79, "rst_addr_r_ack");
        check("rdata_drive_before_rst", {31'd0, sda_oe_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rdata_oe_in_rst", {31'd0, sda_oe_o}, 32'd0);
        check("rdata_busy_in_rst", {31'd0, busy_o}, 32'd0);
        wait_q();
        rst_ni = 1'b1;
        oe0 = oe_cnt;
        m_bit(1'b1, s);
        m_bit(1'b1, s);
        m_stop();
        wait_q();
        check("post_rst_oe_cycles", oe_cnt - oe0, 32'd0);

        // Recovery: a fresh write works after the reset.
        m_start();
        exp_bus_q.push_back(8'h00); write_byte(8'h78, "rec_addr_ack");
        exp_bus_q.push_back(8'h00); write_byte(8'h05, "rec_ptr_ack");
        exp_we_q.push_back(16'h0566);
        exp_bus_q.push_back(8'h00); write_byte(8'h66, "rec_d0_ack");
        m_stop();
        wait_q();
        wait_q();

        check("we_queue_drained", exp_we_q.size(), 32'd0);
        check("bus_queue_drained", exp_bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
